// File: rtl/g_sensor_spi_ctrl.sv
// g_sensor_spi_ctrl: SPI mode-3 master for a 3-axis accelerometer.
// It writes the three configuration registers when enabled. It then reads
// the six data bytes on a periodic timer or on an INT1 rising edge.
//   clk, reset_n    : clock, asynchronous active-low reset
//   enable          : level, permits configuration and sampling
//   g_int1          : asynchronous sensor interrupt
//   spi_*           : 4-wire SPI (cs_n, sclk, sdi = MOSI, sdo = MISO)
//   accel_x/y/z     : last complete sample, two's complement
//   sample_valid    : one-clk pulse when accel_* update
//   init_done       : configuration writes complete
//   busy            : chip select low or inter-transaction gap
module g_sensor_spi_ctrl #(
    parameter int unsigned CLK_DIV       = 25,
    parameter int unsigned SAMPLE_PERIOD = 500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        g_int1,
    input  logic        spi_sdo,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_sdi,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic        sample_valid,
    output logic        init_done,
    output logic        busy
);

    localparam int unsigned DIV_W    = 8;
    localparam int unsigned PH_W     = 7;
    localparam int unsigned GAP_W    = 10;
    localparam int unsigned TMR_W    = 24;
    localparam int unsigned RD_BITS  = 56;
    localparam int unsigned CFG_BITS = 16;

    typedef enum logic [2:0] {
        S_OFF,
        S_CFG,
        S_XFER,
        S_GAP,
        S_WAIT,
        S_READ
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [DIV_W-1:0]   r_div;
    logic [PH_W-1:0]    r_ph;
    logic [PH_W-1:0]    r_last_ph;
    logic [GAP_W-1:0]   r_gap;
    logic [TMR_W-1:0]   r_timer;
    logic [1:0]         r_cfg_idx;
    logic               r_is_read;
    logic [55:0]        r_tx;
    logic [47:0]        r_rx;
    logic [2:0]         r_sync;
    logic               r_pending;
    logic               r_rd_done;
    logic               r_cs_n;
    logic               r_sclk;
    logic               r_sdi;
    logic [15:0]        r_ax;
    logic [15:0]        r_ay;
    logic [15:0]        r_az;
    logic               r_sample_valid;
    logic               r_init_done;
    logic               r_busy;

    logic               w_div_end;
    logic               w_xfer_end;
    logic               w_gap_end;
    logic               w_int_rise;
    logic               w_tmr_hit;
    logic               w_trig;
    logic               w_load;
    logic               w_act_nxt;
    logic               w_shifting;
    logic [1:0]         w_cfg_idx_nxt;

    // Configuration write sequence: {address, data}
    function automatic logic [15:0] cfg_word(input logic [1:0] idx);
        case (idx)
            2'd0:    cfg_word = 16'h310B;
            2'd1:    cfg_word = 16'h2C0A;
            default: cfg_word = 16'h2D08;
        endcase
    endfunction

    // Phase 0 is the lead-in after cs_n falls. Odd phases hold sclk low and
    // even phases hold it high. The final phase is the trail before cs_n rises.
    assign w_div_end     = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_xfer_end    = (r_state == S_XFER) && w_div_end && (r_ph == r_last_ph);
    assign w_gap_end     = (r_state == S_GAP) && (r_gap == GAP_W'(4 * CLK_DIV - 1));
    assign w_int_rise    = r_sync[1] & ~r_sync[2];
    assign w_tmr_hit     = (r_timer == TMR_W'(SAMPLE_PERIOD - 1));
    // Triggers only matter once the sensor has been configured
    assign w_trig        = r_init_done & (w_int_rise | w_tmr_hit);
    assign w_load        = (w_state_nxt == S_CFG) || (w_state_nxt == S_READ);
    assign w_act_nxt     = w_load || (w_state_nxt == S_XFER);
    assign w_shifting    = ((r_state == S_CFG) || (r_state == S_READ) || (r_state == S_XFER))
                           && (w_state_nxt == S_XFER);
    assign w_cfg_idx_nxt = (r_state == S_GAP) ? r_cfg_idx + 2'd1 : 2'd0;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; dropping enable aborts from anywhere
    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = S_OFF;
        end else begin
            case (r_state)
                S_OFF:  w_state_nxt = S_CFG;
                S_CFG:  w_state_nxt = S_XFER;
                S_READ: w_state_nxt = S_XFER;
                S_XFER: if (w_xfer_end) w_state_nxt = S_GAP;
                S_GAP: begin
                    if (w_gap_end) begin
                        if (!r_init_done) begin
                            w_state_nxt = (r_cfg_idx == 2'd2) ? S_WAIT : S_CFG;
                        end else if (r_pending || w_trig) begin
                            w_state_nxt = S_READ;
                        end else begin
                            w_state_nxt = S_WAIT;
                        end
                    end
                end
                S_WAIT: if (w_trig) w_state_nxt = S_READ;
                default: w_state_nxt = S_OFF;
            endcase
        end
    end

    // INT1 two-flop synchronizer plus one flop for edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[1:0], g_int1};
        end
    end

    // Shift engine, SPI pins and sample capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div          <= '0;
            r_ph           <= '0;
            r_last_ph      <= '0;
            r_cfg_idx      <= '0;
            r_is_read      <= 1'b0;
            r_tx           <= '0;
            r_rx           <= '0;
            r_cs_n         <= 1'b1;
            r_sclk         <= 1'b1;
            r_sdi          <= 1'b0;
            r_busy         <= 1'b0;
            r_rd_done      <= 1'b0;
            r_ax           <= '0;
            r_ay           <= '0;
            r_az           <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_cs_n         <= ~w_act_nxt;
            r_busy         <= w_act_nxt || (w_state_nxt == S_GAP);
            r_sample_valid <= 1'b0;
            if (w_load) begin
                r_div  <= '0;
                r_ph   <= '0;
                r_sclk <= 1'b1;
                r_sdi  <= 1'b0;
                if (w_state_nxt == S_READ) begin
                    r_tx      <= {8'hF2, 48'h0};
                    r_last_ph <= PH_W'(2 * RD_BITS + 1);
                    r_is_read <= 1'b1;
                end else begin
                    r_tx      <= {cfg_word(w_cfg_idx_nxt), 40'h0};
                    r_last_ph <= PH_W'(2 * CFG_BITS + 1);
                    r_is_read <= 1'b0;
                    r_cfg_idx <= w_cfg_idx_nxt;
                end
            end else if (w_shifting) begin
                if (w_div_end) begin
                    r_div <= '0;
                    r_ph  <= r_ph + PH_W'(1);
                    if (r_ph[0]) begin
                        // Rising edge: sample MISO; the command byte falls off the top
                        r_sclk <= 1'b1;
                        r_rx   <= {r_rx[46:0], spi_sdo};
                    end else if (r_ph < r_last_ph - PH_W'(1)) begin
                        // Falling edge: present next MOSI bit
                        r_sclk <= 1'b0;
                        r_sdi  <= r_tx[55];
                        r_tx   <= {r_tx[54:0], 1'b0};
                    end
                end else begin
                    r_div <= r_div + DIV_W'(1);
                end
            end else begin
                r_sclk <= 1'b1;
                r_sdi  <= 1'b0;
            end
            // A read counts only if it ran to cs_n rising; publish one clk later
            r_rd_done <= (r_state == S_XFER) && (w_state_nxt == S_GAP) && r_is_read;
            if (r_rd_done && (w_state_nxt != S_OFF)) begin
                r_ax           <= {r_rx[39:32], r_rx[47:40]};
                r_ay           <= {r_rx[23:16], r_rx[31:24]};
                r_az           <= {r_rx[7:0],   r_rx[15:8]};
                r_sample_valid <= 1'b1;
            end
        end
    end

    // Gap counter, sample timer, pending trigger and init flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gap       <= '0;
            r_timer     <= '0;
            r_pending   <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            if (r_state != S_GAP) begin
                r_gap <= '0;
            end else begin
                r_gap <= r_gap + GAP_W'(1);
            end

            // The timer keeps running through reads so that read starts are
            // SAMPLE_PERIOD apart. It is cleared while unconfigured and on each read.
            if (!r_init_done || (w_state_nxt == S_READ) || w_tmr_hit) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TMR_W'(1);
            end

            if ((w_state_nxt == S_OFF) || (w_state_nxt == S_READ)) begin
                r_pending <= 1'b0;
            end else if (w_trig && ((r_state == S_READ) || (r_state == S_XFER) ||
                                    (r_state == S_GAP))) begin
                r_pending <= 1'b1;
            end

            if (w_state_nxt == S_OFF) begin
                r_init_done <= 1'b0;
            end else if ((r_state == S_GAP) && (w_state_nxt == S_WAIT)) begin
                r_init_done <= 1'b1;
            end
        end
    end

    assign spi_cs_n     = r_cs_n;
    assign spi_sclk     = r_sclk;
    assign spi_sdi      = r_sdi;
    assign accel_x      = r_ax;
    assign accel_y      = r_ay;
    assign accel_z      = r_az;
    assign sample_valid = r_sample_valid;
    assign init_done    = r_init_done;
    assign busy         = r_busy;

endmodule
